// File: rtl/xkbuf_pkg.sv
// Shared constants and types for the keyboard event buffer.
// Event layout inside the FIFO is {ext, brk, code[7:0]}; data_out adds {ovf, nempty} on top.
package xkbuf_pkg;

  localparam logic [15:0] KBUF_BASE = 16'h0060;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  localparam int CODE_LSB   = 0;
  localparam int BRK_BIT    = 8;
  localparam int EXT_BIT    = 9;
  localparam int NEMPTY_BIT = 10;
  localparam int OVF_BIT    = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0
  } pfx_st_t;

  // Receiver status/ack bytes that carry no key information when seen unprefixed.
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/xkbuf_fifo.sv
// Generic synchronous FIFO: push dropped when full unless a pop frees a slot the same edge.
// Pop on empty is ignored; flush dominates push and pop.
module xkbuf_fifo #(
  parameter int W     = 10,
  parameter int DLOG2 = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     wdat,
  output logic [W-1:0]     rdat,
  output logic             full,
  output logic             empty,
  output logic [DLOG2:0]   count
);

  localparam int             DEPTH    = 1 << DLOG2;
  localparam logic [DLOG2:0] FULL_CNT = (DLOG2 + 1)'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [DLOG2-1:0] r_wptr;
  logic [DLOG2-1:0] r_rptr;
  logic [DLOG2:0]   r_cnt;

  logic w_pop;
  logic w_push;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == FULL_CNT);
  assign count  = r_cnt;
  assign rdat   = r_mem[r_rptr];
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush && !rst) r_mem[r_wptr] <= wdat;
  end

endmodule

// File: rtl/xkbuf.sv
// Keyboard event buffer: folds E0/F0 prefixes into single events and queues them for bus polling.
// Events land on the in_valid edge; a bus read returns the head combinationally and pops it.
module xkbuf
  import xkbuf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int EVT_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_code,
  input  logic             sel,
  input  logic             we,
  input  logic [1:0]       data_in,
  output logic [EVT_W+1:0] data_out,
  output logic             irq
);

  pfx_st_t r_st;
  pfx_st_t w_st_nxt;
  logic    r_ovf;

  logic                  w_push;
  logic                  w_ext;
  logic                  w_brk;
  logic [EVT_W-1:0]      w_evt;
  logic [EVT_W-1:0]      w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [DEPTH_LOG2:0]   w_count;

  logic w_rd;
  logic w_wr;
  logic w_flush;
  logic w_ovf_clr;
  logic w_ovf_set;

  assign w_rd      = sel & ~we;
  assign w_wr      = sel & we;
  assign w_flush   = w_wr & data_in[0];
  assign w_ovf_clr = w_wr & data_in[1];
  // A same-cycle pop frees the slot, so only an unrelieved push into a full FIFO overflows.
  assign w_ovf_set = w_push & w_full & ~(w_rd & ~w_empty) & ~w_flush;

  always_ff @(posedge clk) begin
    if (rst) r_st <= ST_IDLE;
    else     r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    w_push   = 1'b0;
    w_ext    = 1'b0;
    w_brk    = 1'b0;
    if (in_valid) begin
      case (r_st)
        ST_IDLE: begin
          if (in_code == PFX_EXT)      w_st_nxt = ST_E0;
          else if (in_code == PFX_BRK) w_st_nxt = ST_F0;
          else if (!is_discard(in_code)) w_push = 1'b1;
        end
        ST_E0: begin
          if (in_code == PFX_BRK)      w_st_nxt = ST_E0F0;
          else if (in_code == PFX_EXT) w_st_nxt = ST_E0;
          else begin
            w_push   = 1'b1;
            w_ext    = 1'b1;
            w_st_nxt = ST_IDLE;
          end
        end
        ST_F0: begin
          if (in_code == PFX_BRK)      w_st_nxt = ST_F0;
          else if (in_code == PFX_EXT) w_st_nxt = ST_E0F0;
          else begin
            w_push   = 1'b1;
            w_brk    = 1'b1;
            w_st_nxt = ST_IDLE;
          end
        end
        default: begin
          if (in_code != PFX_EXT && in_code != PFX_BRK) begin
            w_push   = 1'b1;
            w_ext    = 1'b1;
            w_brk    = 1'b1;
            w_st_nxt = ST_IDLE;
          end
        end
      endcase
    end
    if (w_flush) w_st_nxt = ST_IDLE;
  end

  always_comb begin
    w_evt                     = '0;
    w_evt[CODE_LSB +: 8]      = in_code;
    w_evt[BRK_BIT]            = w_brk;
    w_evt[EXT_BIT]            = w_ext;
  end

  // Set dominates clear so an overflow in the clearing cycle is never hidden.
  always_ff @(posedge clk) begin
    if (rst)            r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (w_ovf_clr) r_ovf <= 1'b0;
  end

  xkbuf_fifo #(
    .W     (EVT_W),
    .DLOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_rd),
    .flush (w_flush),
    .wdat  (w_evt),
    .rdat  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_comb begin
    data_out             = '0;
    data_out[OVF_BIT]    = r_ovf;
    data_out[NEMPTY_BIT] = ~w_empty;
    if (!w_empty) data_out[EVT_W-1:0] = w_head;
  end

  assign irq = (w_count != '0);

endmodule

// File: tb/tb_xkbuf.sv
// Testbench for xkbuf: hand-computed vector table, then a queue scoreboard for corner sequences and random traffic.
module tb_xkbuf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_code = 8'h00;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  data_in = 2'b00;
  logic [11:0] data_out;
  logic        irq;

  xkbuf dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_code  (in_code),
    .sel      (sel),
    .we       (we),
    .data_in  (data_in),
    .data_out (data_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [9:0] sb_q[$];
  logic       m_ovf = 1'b0;
  int         m_st  = 0;

  typedef struct {
    bit          v;
    logic [7:0]  c;
    bit          rd;
    bit          wr;
    logic [1:0]  d;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit is_disc(input logic [7:0] b);
    return (b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
            b == 8'hFC || b == 8'hFD || b == 8'hFE || b == 8'hFF);
  endfunction

  function automatic logic [11:0] model_dout();
    logic [11:0] r;
    r     = 12'h000;
    r[11] = m_ovf;
    if (sb_q.size() > 0) begin
      r[10]  = 1'b1;
      r[9:0] = sb_q[0];
    end
    return r;
  endfunction

  function automatic void add(input bit v, input logic [7:0] c, input bit rd,
                              input bit wr, input logic [1:0] d, input logic [11:0] exp);
    vec_t e;
    e.v = v; e.c = c; e.rd = rd; e.wr = wr; e.d = d; e.exp = exp;
    tbl.push_back(e);
  endfunction

  // One bus/receiver cycle: check outputs against the scoreboard, update the model, drive the DUT.
  task automatic cyc(input bit v, input logic [7:0] c, input bit rd, input bit wr,
                     input logic [1:0] d, input string nm);
    bit         push;
    bit         pop;
    logic [9:0] ev;
    chk({nm, " dout"}, data_out, model_dout());
    chk({nm, " irq"}, {11'h0, irq}, {11'h0, sb_q.size() != 0});
    push = 0;
    ev   = 10'h0;
    if (v) begin
      case (m_st)
        0: begin
          if (c == 8'hE0)      m_st = 1;
          else if (c == 8'hF0) m_st = 2;
          else if (!is_disc(c)) begin push = 1; ev = {2'b00, c}; end
        end
        1: begin
          if (c == 8'hF0)      m_st = 3;
          else if (c == 8'hE0) m_st = 1;
          else begin push = 1; ev = {2'b10, c}; m_st = 0; end
        end
        2: begin
          if (c == 8'hF0)      m_st = 2;
          else if (c == 8'hE0) m_st = 3;
          else begin push = 1; ev = {2'b01, c}; m_st = 0; end
        end
        default: begin
          if (c != 8'hE0 && c != 8'hF0) begin push = 1; ev = {2'b11, c}; m_st = 0; end
        end
      endcase
    end
    pop = rd && !wr && sb_q.size() > 0;
    if (wr && d[0]) begin
      sb_q.delete();
      m_st = 0;
      if (d[1]) m_ovf = 1'b0;
    end else begin
      if (wr && d[1]) m_ovf = 1'b0;
      if (pop) void'(sb_q.pop_front());
      if (push) begin
        if (sb_q.size() < 8) sb_q.push_back(ev);
        else                 m_ovf = 1'b1;
      end
    end
    in_valid = v;
    in_code  = c;
    sel      = rd | wr;
    we       = wr;
    data_in  = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    sel      = 1'b0;
    we       = 1'b0;
    data_in  = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    sb_q.delete();
    m_ovf = 1'b0;
    m_st  = 0;
  endtask

  initial begin
    logic [7:0] b;
    bit         rd;
    bit         wr;
    logic [1:0] d;

    @(negedge clk);
    do_reset();

    // Hand-computed table covering the basic event, prefix folding, discard and overflow paths.
    add(0, 8'h00, 1, 0, 2'b00, 12'h000);
    add(1, 8'h1C, 0, 0, 2'b00, 12'h000);
    add(0, 8'h00, 1, 0, 2'b00, 12'h41C);
    add(0, 8'h00, 1, 0, 2'b00, 12'h000);
    add(1, 8'hE0, 0, 0, 2'b00, 12'h000);
    add(1, 8'hF0, 0, 0, 2'b00, 12'h000);
    add(1, 8'h75, 0, 0, 2'b00, 12'h000);
    add(0, 8'h00, 1, 0, 2'b00, 12'h775);
    add(1, 8'hF0, 0, 0, 2'b00, 12'h000);
    add(1, 8'h1C, 0, 0, 2'b00, 12'h000);
    add(1, 8'hE0, 0, 0, 2'b00, 12'h51C);
    add(1, 8'h75, 0, 0, 2'b00, 12'h51C);
    add(1, 8'hAA, 0, 0, 2'b00, 12'h51C);
    add(1, 8'hFA, 0, 0, 2'b00, 12'h51C);
    add(0, 8'h00, 1, 0, 2'b00, 12'h51C);
    add(0, 8'h00, 1, 0, 2'b00, 12'h675);
    add(0, 8'h00, 1, 0, 2'b00, 12'h000);
    for (int i = 1; i <= 9; i++)
      add(1, 8'(i), 0, 0, 2'b00, (i == 1) ? 12'h000 : 12'h401);
    for (int i = 1; i <= 8; i++)
      add(0, 8'h00, 1, 0, 2'b00, 12'hC00 | 12'(i));
    add(0, 8'h00, 1, 0, 2'b00, 12'h800);
    add(0, 8'h00, 0, 1, 2'b10, 12'h800);
    add(0, 8'h00, 1, 0, 2'b00, 12'h000);

    for (int i = 0; i < tbl.size(); i++) begin
      chk($sformatf("tbl%0d", i), data_out, tbl[i].exp);
      cyc(tbl[i].v, tbl[i].c, tbl[i].rd, tbl[i].wr, tbl[i].d, $sformatf("tbl%0d", i));
    end

    // Full FIFO with simultaneous push and pop.
    for (int i = 1; i <= 8; i++) cyc(1, 8'h10 + 8'(i), 0, 0, 2'b00, "fill");
    chk("full_head", data_out, 12'h411);
    cyc(1, 8'h20, 1, 0, 2'b00, "full_pushpop");
    for (int i = 2; i <= 8; i++) begin
      chk("full_drain", data_out, 12'h410 | 12'(i));
      cyc(0, 8'h00, 1, 0, 2'b00, "full_drain");
    end
    chk("full_tail", data_out, 12'h420);
    cyc(0, 8'h00, 1, 0, 2'b00, "full_tail");
    chk("full_noovf", data_out, 12'h000);

    // Overflow coinciding with an ovf-clear write: set must win.
    for (int i = 0; i < 8; i++) cyc(1, 8'h30 + 8'(i), 0, 0, 2'b00, "fill2");
    cyc(1, 8'h38, 0, 1, 2'b10, "ovf_vs_clr");
    chk("ovf_set_wins", data_out, 12'hC30);
    cyc(0, 8'h00, 0, 1, 2'b11, "flush_clr");
    chk("flush_clr", data_out, 12'h000);

    // Push coinciding with flush: the event is lost.
    cyc(1, 8'h1C, 0, 1, 2'b01, "push_flush");
    chk("push_flush", data_out, 12'h000);

    // Reset in the middle of an extended sequence.
    cyc(1, 8'hE0, 0, 0, 2'b00, "pre_rst");
    do_reset();
    chk("rst_dout", data_out, 12'h000);
    chk("rst_irq", {11'h0, irq}, 12'h000);
    cyc(1, 8'h75, 0, 0, 2'b00, "post_rst");
    chk("post_rst", data_out, 12'h475);
    cyc(0, 8'h00, 1, 0, 2'b00, "post_rst_rd");

    // Flush while a break prefix is pending.
    cyc(1, 8'hF0, 0, 0, 2'b00, "pend_f0");
    cyc(0, 8'h00, 0, 1, 2'b01, "flush_f0");
    cyc(1, 8'h1C, 0, 0, 2'b00, "after_flush");
    chk("after_flush", data_out, 12'h41C);
    cyc(0, 8'h00, 1, 0, 2'b00, "after_flush_rd");

    // Random traffic against the scoreboard.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = 8'hAA;
        default: b = 8'($urandom_range(0, 255));
      endcase
      wr = ($urandom_range(0, 19) == 0);
      rd = !wr && ($urandom_range(0, 9) < 3);
      d  = 2'($urandom_range(0, 3));
      cyc($urandom_range(0, 9) < 6, b, rd, wr, wr ? d : 2'b00, "rand");
    end
    while (sb_q.size() > 0) cyc(0, 8'h00, 1, 0, 2'b00, "drain");
    chk("final_empty", {11'h0, irq}, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
